// File: rtl/alu_pkg.sv
// alu_pkg: opcode enums, irq FSM states, trigger constants, command/result structs and op helpers.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_A_AND  = 2'b00,
    OP_A_NAND = 2'b01,
    OP_A_OR   = 2'b10,
    OP_A_XOR  = 2'b11
  } operation_a;

  typedef enum logic [1:0] {
    OP_B_XNOR = 2'b00,
    OP_B_AND  = 2'b01,
    OP_B_NOR  = 2'b10,
    OP_B_OR   = 2'b11
  } operation_b;

  typedef enum logic {
    IRQ_IDLE = 1'b0,
    IRQ_PEND = 1'b1
  } irq_state_e;

  localparam logic [7:0] TRIG_A_AND  = 8'hFF;
  localparam logic [7:0] TRIG_A_NAND = 8'h00;
  localparam logic [7:0] TRIG_A_OR   = 8'hF8;
  localparam logic [7:0] TRIG_B_XNOR = 8'hF1;
  localparam logic [7:0] TRIG_B_AND  = 8'hF4;
  localparam logic [7:0] TRIG_B_NOR  = 8'hF5;
  localparam logic [7:0] ALU_ERR_OUT = 8'hFF;

  typedef struct packed {
    logic       enable;
    logic       enable_a;
    logic       enable_b;
    operation_a op_a;
    operation_b op_b;
    logic [7:0] in_a;
    logic [7:0] in_b;
  } alu_cmd_t;

  typedef struct packed {
    logic       accept;
    logic [7:0] result;
    logic       trigger;
  } alu_res_t;

  function automatic logic [7:0] calc_a(operation_a op, logic [7:0] a, logic [7:0] b);
    unique case (op)
      OP_A_AND:  calc_a = a & b;
      OP_A_NAND: calc_a = ~(a & b);
      OP_A_OR:   calc_a = a | b;
      OP_A_XOR:  calc_a = a ^ b;
    endcase
  endfunction

  function automatic logic [7:0] calc_b(operation_b op, logic [7:0] a, logic [7:0] b);
    unique case (op)
      OP_B_XNOR: calc_b = ~(a ^ b);
      OP_B_AND:  calc_b = a & b;
      OP_B_NOR:  calc_b = ~(a | b);
      OP_B_OR:   calc_b = a | b;
    endcase
  endfunction

  // XOR (mode A) and OR (mode B) have no trigger value
  function automatic logic trig_a(operation_a op, logic [7:0] r);
    unique case (op)
      OP_A_AND:  trig_a = (r == TRIG_A_AND);
      OP_A_NAND: trig_a = (r == TRIG_A_NAND);
      OP_A_OR:   trig_a = (r == TRIG_A_OR);
      OP_A_XOR:  trig_a = 1'b0;
    endcase
  endfunction

  function automatic logic trig_b(operation_b op, logic [7:0] r);
    unique case (op)
      OP_B_XNOR: trig_b = (r == TRIG_B_XNOR);
      OP_B_AND:  trig_b = (r == TRIG_B_AND);
      OP_B_NOR:  trig_b = (r == TRIG_B_NOR);
      OP_B_OR:   trig_b = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_if.sv
// alu_if: ALU command bus; master drives commands and irq clear, slave returns result and irq.
interface alu_if;
  import alu_pkg::*;

  logic       alu_enable;
  logic       alu_enable_a;
  logic       alu_enable_b;
  operation_a alu_op_a;
  operation_b alu_op_b;
  logic [7:0] alu_in_a;
  logic [7:0] alu_in_b;
  logic       alu_irq_clr;
  logic       alu_irq;
  logic [7:0] alu_out;

  modport master (
    output alu_enable, alu_enable_a, alu_enable_b, alu_op_a, alu_op_b,
    output alu_in_a, alu_in_b, alu_irq_clr,
    input  alu_irq, alu_out
  );

  modport slave (
    input  alu_enable, alu_enable_a, alu_enable_b, alu_op_a, alu_op_b,
    input  alu_in_a, alu_in_b, alu_irq_clr,
    output alu_irq, alu_out
  );

endinterface

// File: rtl/alu_op_unit.sv
// alu_op_unit: combinational decode of one command into result, accept and trigger; zero latency, no backpressure.
// With ALU_ILLEGAL_IRQ_EN defined, both selects high is accepted as an error result that triggers.
module alu_op_unit
  import alu_pkg::*;
(
  input  alu_cmd_t cmd,
  output alu_res_t res
);

  always_comb begin
    res = '0;
    if (cmd.enable && cmd.enable_a && !cmd.enable_b) begin
      res.accept  = 1'b1;
      res.result  = calc_a(cmd.op_a, cmd.in_a, cmd.in_b);
      res.trigger = trig_a(cmd.op_a, calc_a(cmd.op_a, cmd.in_a, cmd.in_b));
    end else if (cmd.enable && cmd.enable_b && !cmd.enable_a) begin
      res.accept  = 1'b1;
      res.result  = calc_b(cmd.op_b, cmd.in_a, cmd.in_b);
      res.trigger = trig_b(cmd.op_b, calc_b(cmd.op_b, cmd.in_a, cmd.in_b));
    end
`ifdef ALU_ILLEGAL_IRQ_EN
    else if (cmd.enable && cmd.enable_a && cmd.enable_b) begin
      res.accept  = 1'b1;
      res.result  = ALU_ERR_OUT;
      res.trigger = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/alu_core.sv
// alu_core: ALU responder with registered result and sticky irq; latency 1 cycle, no backpressure (a command every cycle).
// Build option ALU_ILLEGAL_IRQ_EN turns an illegal dual-select command into an error result plus irq.
module alu_core
  import alu_pkg::*;
#(
  parameter bit OUT_HOLD     = 1'b1,
  parameter bit IRQ_CLR_WINS = 1'b0
) (
  input  logic  clk,
  input  logic  rst_n,
  alu_if.slave  bus
);

  alu_cmd_t   cmd;
  alu_res_t   res;
  logic [7:0] out_q;
  logic       trig;
  irq_state_e irq_state;
  irq_state_e irq_next;

  assign cmd = '{
    enable:   bus.alu_enable,
    enable_a: bus.alu_enable_a,
    enable_b: bus.alu_enable_b,
    op_a:     bus.alu_op_a,
    op_b:     bus.alu_op_b,
    in_a:     bus.alu_in_a,
    in_b:     bus.alu_in_b
  };

  alu_op_unit u_op_unit (
    .cmd (cmd),
    .res (res)
  );

  assign trig = res.accept && res.trigger;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q <= 8'h00;
    end else if (res.accept) begin
      out_q <= res.result;
    end else if (!OUT_HOLD) begin
      out_q <= 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_state <= IRQ_IDLE;
    end else begin
      irq_state <= irq_next;
    end
  end

  // A clear and a trigger in the same cycle resolve by IRQ_CLR_WINS in either state
  always_comb begin
    irq_next = irq_state;
    unique case (irq_state)
      IRQ_IDLE: begin
        if (trig && !(bus.alu_irq_clr && IRQ_CLR_WINS)) begin
          irq_next = IRQ_PEND;
        end
      end
      IRQ_PEND: begin
        if (bus.alu_irq_clr && !(trig && !IRQ_CLR_WINS)) begin
          irq_next = IRQ_IDLE;
        end
      end
    endcase
  end

  assign bus.alu_out = out_q;
  assign bus.alu_irq = (irq_state == IRQ_PEND);

endmodule
